f_pc_predict: RTL
=================

# f_pc_predict

Fetch-stage PC unit for the pipelined MIPS core: holds the F-stage PC and chooses the next PC using a parametrised, direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It replaces static "no-branch means PC+4" sequencing with predicted redirection in F. When the D stage resolves a control instruction, this block receives the outcome, detects mispredictions, redirects the PC and trains the table.

## Interface
Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 2 to 256
- RESET_PC, 32'h0000_3000, PC loaded on reset
- IDX_W, $clog2(ENTRIES), index width (derived, not overridden)

Ports:
- clk  in  1  single clock, posedge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC_F (F/D hazard stall)
- PC_F  out  32  current fetch PC
- pred_taken_F  out  1  prediction for PC_F, combinational
- pred_target_F  out  32  predicted next PC for PC_F, combinational
- upd_valid  in  1  D holds a resolved control instruction this cycle
- upd_pc  in  32  PC of that instruction
- upd_taken  in  1  actual direction (jal/jr: always 1)
- upd_target  in  32  actual target
- upd_fallthrough  in  32  correct PC when not taken
- upd_pred_taken  in  1  pred_taken_F carried with the instruction
- upd_pred_target  in  32  pred_target_F carried with the instruction
- mispredict  out  1  combinational; D uses it to flush F/D

## Operation
- Entry fields: valid, tag = pc[31:IDX_W+2], target[31:0], ctr[1:0]. Index = pc[IDX_W+1:2]; pc[1:0] ignored.
- Lookup (asynchronous read on PC_F):
  - hit = valid && tag match.
  - pred_taken_F = hit && ctr[1].
  - pred_target_F = pred_taken_F ? target : PC_F+4.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- mispredict = upd_valid && ((upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target)).
- Next PC, in priority order:
  - reset: RESET_PC.
  - mispredict: upd_taken ? upd_target : upd_fallthrough. This overrides stall.
  - stall: PC_F unchanged.
  - otherwise: pred_target_F.
- Training, at posedge when upd_valid is set (independent of stall and mispredict):
  - Hit at idx(upd_pc), taken: ctr increments, saturating at 11; target = upd_target.
  - Hit, not taken: ctr decrements, saturating at 00; target unchanged.
  - Miss, taken: allocate, overwriting any aliasing entry. valid=1, tag, target = upd_target, ctr = 10.
  - Miss, not taken: no write.
- Reset: every valid=0, ctr=01, PC_F=RESET_PC. As a result pred_taken_F=0 and pred_target_F=RESET_PC+4.
- upd_valid must be asserted only when D is not stalled. The block does not check this.
- Arithmetic is modulo 2^32. PC_F+4 wraps from 0xFFFF_FFFC to 0.

## Timing
- One cycle from a decision to the new PC_F: PC_F registers at posedge.
- Prediction has zero latency: it is combinational from PC_F and table state.
- mispredict is combinational from the upd_* inputs in the same cycle. The redirect is visible in PC_F on the next edge.
- A table write becomes visible to lookups the cycle after the edge.
- Same-cycle lookup of an index being written returns the old contents.
- Reset asserted mid-operation wins over everything on that edge. Table contents are discarded.
- Simultaneous stall and mispredict: the redirect is taken.
- Simultaneous upd to idx i while PC_F indexes i: the prediction uses the old entry, and the write still happens.

## Test plan
- Reset with ENTRIES=16: assert reset 2 cycles, release. Required: PC_F=0x3000, pred_taken_F=0, then 0x3004, 0x3008 on successive edges.
- First-time taken branch: upd_valid, upd_pc=0x3008, upd_taken=1, upd_target=0x3000, upd_pred_taken=0. Required: mispredict=1, next PC_F=0x3000, entry 2 allocated with ctr=10. When PC_F later reaches 0x3008, required: pred_taken_F=1, pred_target_F=0x3000.
- Counter saturation: train 0x3008 taken 3 more times (ctr=11), then not-taken twice. Required: ctr=01 and pred_taken_F=0 at 0x3008. One further not-taken gives ctr=00; a further decrement stays at 00.
- Stall: stall=1 for 3 cycles with no update. Required: PC_F holds its value. Assert mispredict during the stall with upd_taken=0, upd_fallthrough=0x3040. Required: PC_F=0x3040 on the next edge.
- Alias eviction: train 0x3008 taken, then a taken update for 0x3048 (same idx 2, different tag, target 0x3100). Required: 0x3008 now misses (predicts 0x300C), and 0x3048 predicts 0x3100.
- Wrong target: a hit with ctr=11, upd_target=0x3200 differing from upd_pred_target=0x3000. Required: mispredict=1, PC_F=0x3200, entry target updated to 0x3200.

Source files
------------

// File: rtl/f_pc_predict.sv
// Fetch-stage PC register with a direct-mapped BTB (2-bit counters) that predicts the next PC
// and is trained/redirected by control-flow outcomes resolved in D.
module f_pc_predict #(
  parameter int          ENTRIES  = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IDX_W    = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] PC_F,
  output logic        pred_taken_F,
  output logic [31:0] pred_target_F,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic [31:0] upd_fallthrough,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict
);

  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [31:0]        target [ENTRIES];
  logic [1:0]         ctr    [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] f_tag;
  logic [TAG_W-1:0] u_tag;
  logic             f_hit;
  logic             u_hit;
  logic [31:0]      pc_plus4;
  logic [31:0]      redirect_pc;

  assign f_idx = PC_F[IDX_W+1:2];
  assign f_tag = PC_F[31:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];

  // Reads see the table as it was before this edge's write
  assign f_hit = valid[f_idx] && (tag[f_idx] == f_tag);
  assign u_hit = valid[u_idx] && (tag[u_idx] == u_tag);

  assign pc_plus4      = PC_F + 32'd4;
  assign pred_taken_F  = f_hit && ctr[f_idx][1];
  assign pred_target_F = pred_taken_F ? target[f_idx] : pc_plus4;

  assign mispredict  = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_fallthrough;

  always_ff @(posedge clk) begin
    if (reset) begin
      PC_F <= RESET_PC;
    end else if (mispredict) begin
      PC_F <= redirect_pc;
    end else if (!stall) begin
      PC_F <= pred_target_F;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        ctr[i]   <= 2'b01;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken) begin
          target[u_idx] <= upd_target;
          if (ctr[u_idx] != 2'b11) ctr[u_idx] <= ctr[u_idx] + 2'd1;
        end else if (ctr[u_idx] != 2'b00) begin
          ctr[u_idx] <= ctr[u_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocation evicts whatever aliased into this slot
        valid[u_idx]  <= 1'b1;
        tag[u_idx]    <= u_tag;
        target[u_idx] <= upd_target;
        ctr[u_idx]    <= 2'b10;
      end
    end
  end

endmodule
